cpu_sequencer: RTL

//  Control-unit FSM for the basic processor: drives the shared sysbus enables and register loads
//  (PC, IR, ACC, MAR, MDR) and the memory strobes (CS, R_NW) for the ROM/RAM.

---
 rtl/cpu_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control-unit FSM for the basic processor.
// Drives the sysbus enables, the register loads (PC, IR, ACC, MAR, MDR) and the
// memory strobes (CS, R_NW). It sequences FETCH0 -> FETCH1 -> DECODE -> EXEC for
// LOAD/STORE/ADD/SUB. BNE and undefined opcodes retire in DECODE.
// Optional feature: define SEQ_HALT_EN to make op=3'b111 a HALT instruction.
// That build adds the 'halted' output port.
module cpu_sequencer #(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3
) (
   input  logic            clock,
   input  logic            n_reset,
   input  logic [OP_W-1:0] op,
   input  logic            z_flag,
   output logic            PC_bus,
   output logic            load_PC,
   output logic            INC_PC,
   output logic            load_IR,
   output logic            Addr_bus,
   output logic            load_MAR,
   output logic            MDR_bus,
   output logic            load_MDR,
   output logic            ACC_bus,
   output logic            load_ACC,
   output logic            ALU_ACC,
   output logic            ALU_add,
   output logic            ALU_sub,
   output logic            CS,
   output logic            R_NW,
   output logic            instr_done
`ifdef SEQ_HALT_EN
   ,
   output logic            halted
`endif
);

   // The opcode is the top OP_W bits of the IR word, so it can never be wider than the word.
   if (OP_W > WORD_W) begin : g_op_wider_than_word
   end

   // Opcode encodings shared with the datapath.
   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(3'b000);
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(3'b001);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3'b010);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3'b011);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(3'b100);
`ifdef SEQ_HALT_EN
   localparam logic [OP_W-1:0] OP_HALT  = OP_W'(3'b111);
`endif

   typedef enum logic [2:0] {
      S_FETCH0 = 3'd0,
      S_FETCH1 = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3
`ifdef SEQ_HALT_EN
      ,
      S_HALT   = 3'd4
`endif
   } state_t;

   typedef struct packed {
      logic pc_bus;
      logic load_pc;
      logic inc_pc;
      logic load_ir;
      logic addr_bus;
      logic load_mar;
      logic mdr_bus;
      logic load_mdr;
      logic acc_bus;
      logic load_acc;
      logic alu_acc;
      logic alu_add;
      logic alu_sub;
      logic cs;
      logic r_nw;
      logic instr_done;
`ifdef SEQ_HALT_EN
      logic halted;
`endif
   } ctrl_t;

   state_t state;
   ctrl_t  ctrl;
   ctrl_t  ctrl_out;

   // State register: reset restarts at FETCH0 and aborts any instruction in flight.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         state <= S_FETCH0;
      end else begin
         case (state)
            S_FETCH0: state <= S_FETCH1;
            S_FETCH1: state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state <= S_EXEC;
`ifdef SEQ_HALT_EN
                  OP_HALT:                           state <= S_HALT;
`endif
                  default:                           state <= S_FETCH0;
               endcase
            end
            S_EXEC:   state <= S_FETCH0;
`ifdef SEQ_HALT_EN
            S_HALT:   state <= S_HALT;
`endif
            default:  state <= S_FETCH0;
         endcase
      end
   end

   // Strobe decode from the current state and opcode; anything not named stays 0.
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH0: begin
            ctrl.pc_bus   = 1'b1;
            ctrl.load_mar = 1'b1;
            ctrl.load_pc  = 1'b1;
            ctrl.inc_pc   = 1'b1;
         end
         S_FETCH1: begin
            ctrl.cs      = 1'b1;
            ctrl.r_nw    = 1'b1;
            ctrl.mdr_bus = 1'b1;
            ctrl.load_ir = 1'b1;
         end
         S_DECODE: begin
            ctrl.addr_bus = 1'b1;
            ctrl.load_mar = 1'b1;
            case (op)
               OP_LOAD, OP_STORE, OP_ADD, OP_SUB: ctrl.instr_done = 1'b0;
               OP_BNE: begin
                  // Taken branch: PC loads the target from the address field on sysbus.
                  if (!z_flag) begin
                     ctrl.load_pc = 1'b1;
                  end else begin
                     ctrl.load_pc = 1'b0;
                  end
                  ctrl.instr_done = 1'b1;
               end
               default: ctrl.instr_done = 1'b1;
            endcase
         end
         S_EXEC: begin
            ctrl.instr_done = 1'b1;
            case (op)
               OP_LOAD: begin
                  ctrl.cs       = 1'b1;
                  ctrl.r_nw     = 1'b1;
                  ctrl.mdr_bus  = 1'b1;
                  ctrl.load_acc = 1'b1;
               end
               OP_STORE: begin
                  ctrl.acc_bus  = 1'b1;
                  ctrl.load_mdr = 1'b1;
                  ctrl.cs       = 1'b1;
               end
               OP_ADD: begin
                  ctrl.cs       = 1'b1;
                  ctrl.r_nw     = 1'b1;
                  ctrl.mdr_bus  = 1'b1;
                  ctrl.alu_acc  = 1'b1;
                  ctrl.alu_add  = 1'b1;
                  ctrl.load_acc = 1'b1;
               end
               OP_SUB: begin
                  ctrl.cs       = 1'b1;
                  ctrl.r_nw     = 1'b1;
                  ctrl.mdr_bus  = 1'b1;
                  ctrl.alu_acc  = 1'b1;
                  ctrl.alu_sub  = 1'b1;
                  ctrl.load_acc = 1'b1;
               end
               default: ctrl.instr_done = 1'b1;
            endcase
         end
`ifdef SEQ_HALT_EN
         S_HALT: ctrl.halted = 1'b1;
`endif
         default: ctrl = '0;
      endcase
   end

   // Reset masks every output immediately, so no strobe fires during reset.
   assign ctrl_out   = n_reset ? ctrl : '0;

   assign PC_bus     = ctrl_out.pc_bus;
   assign load_PC    = ctrl_out.load_pc;
   assign INC_PC     = ctrl_out.inc_pc;
   assign load_IR    = ctrl_out.load_ir;
   assign Addr_bus   = ctrl_out.addr_bus;
   assign load_MAR   = ctrl_out.load_mar;
   assign MDR_bus    = ctrl_out.mdr_bus;
   assign load_MDR   = ctrl_out.load_mdr;
   assign ACC_bus    = ctrl_out.acc_bus;
   assign load_ACC   = ctrl_out.load_acc;
   assign ALU_ACC    = ctrl_out.alu_acc;
   assign ALU_add    = ctrl_out.alu_add;
   assign ALU_sub    = ctrl_out.alu_sub;
   assign CS         = ctrl_out.cs;
   assign R_NW       = ctrl_out.r_nw;
   assign instr_done = ctrl_out.instr_done;
`ifdef SEQ_HALT_EN
   assign halted     = ctrl_out.halted;
`endif

endmodule
